// File: rtl/pwconv_out_collector_if.sv
// Stream interface between PWconv output and the output collector.
// The master side drives beats and consumes groups; the slave side is the collector.
interface pwconv_out_collector_if #(
    parameter int CH    = 32,
    parameter int DW    = 8,
    parameter int CNT_W = 5,
    parameter int POS_W = 4
);
    logic               in_valid;
    logic [CNT_W-1:0]   cnt_in;
    logic [POS_W-1:0]   pos_in;
    logic [DW-1:0]      data_in0;
    logic [DW-1:0]      data_in1;
    logic [DW-1:0]      data_in2;
    logic [DW-1:0]      data_in3;
    logic               stall;
    logic               out_valid;
    logic               out_ready;
    logic [POS_W-1:0]   out_pos;
    logic [0:CH*DW-1]   out_data0;
    logic [0:CH*DW-1]   out_data1;
    logic [0:CH*DW-1]   out_data2;
    logic [0:CH*DW-1]   out_data3;

    modport master (
        output in_valid, cnt_in, pos_in, data_in0, data_in1, data_in2, data_in3, out_ready,
        input  stall, out_valid, out_pos, out_data0, out_data1, out_data2, out_data3
    );

    modport slave (
        input  in_valid, cnt_in, pos_in, data_in0, data_in1, data_in2, data_in3, out_ready,
        output stall, out_valid, out_pos, out_data0, out_data1, out_data2, out_data3
    );
endinterface

// File: rtl/pwconv_out_collector.sv
// Collects 32 channel beats of PWconv results into four packed per-lane vectors
// and hands completed groups downstream through two ping-pong buffers.
// Optional feature: define PWCOLLECT_DROP_CNT_EN to add the 16-bit drop_cnt port,
// a saturating count of cycles where a beat was offered while stalled.
module pwconv_out_collector #(
    parameter int CH    = 32,
    parameter int DW    = 8,
    parameter int CNT_W = 5,
    parameter int POS_W = 4
) (
    input  logic clk,
    input  logic rst_b,
    input  logic en,
    pwconv_out_collector_if.slave bus,
    output logic err_seq
`ifdef PWCOLLECT_DROP_CNT_EN
    ,
    output logic [15:0] drop_cnt
`endif
);

    logic [0:CH*DW-1]  buf_data [2][4];
    logic [POS_W-1:0]  buf_pos  [2];
    logic [1:0]        buf_full;
    logic [1:0]        full_nxt;
    logic              wr_ptr;
    logic              rd_ptr;
    logic [CNT_W-1:0]  exp_cnt;
    logic              stall_q;
    logic              accept;
    logic              pop;
    logic              last_beat;
    logic              seq_bad;

    // Decode this cycle's beat acceptance, pop, and the buffer fullness after this edge
    always_comb begin
        accept    = en && bus.in_valid && !stall_q;
        pop       = en && buf_full[rd_ptr] && bus.out_ready;
        last_beat = accept && (bus.cnt_in == CNT_W'(CH - 1));
        seq_bad   = accept && ((bus.cnt_in != exp_cnt) ||
                               ((exp_cnt != '0) && (bus.pos_in != buf_pos[wr_ptr])));
        full_nxt  = buf_full;
        if (pop) begin
            full_nxt[rd_ptr] = 1'b0;
        end
        if (last_beat) begin
            full_nxt[wr_ptr] = 1'b1;
        end
    end

    // Control state: buffer flags, ping-pong pointers, expected channel, stall and error flags
    always_ff @(posedge clk) begin
        if (rst_b) begin
            buf_full <= 2'b00;
            wr_ptr   <= 1'b0;
            rd_ptr   <= 1'b0;
            exp_cnt  <= '0;
            stall_q  <= 1'b0;
            err_seq  <= 1'b0;
        end else begin
            buf_full <= full_nxt;
            stall_q  <= &full_nxt;
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            if (last_beat) begin
                wr_ptr <= ~wr_ptr;
            end
            if (accept) begin
                exp_cnt <= last_beat ? '0 : bus.cnt_in + CNT_W'(1);
            end
            if (seq_bad) begin
                err_seq <= 1'b1;
            end
        end
    end

    // Buffer storage: write each lane byte at its channel slot, latch the tag on a group's first beat
    always_ff @(posedge clk) begin
        if (rst_b) begin
            for (int b = 0; b < 2; b++) begin
                buf_pos[b] <= '0;
                for (int l = 0; l < 4; l++) begin
                    buf_data[b][l] <= '0;
                end
            end
        end else if (accept) begin
            buf_data[wr_ptr][0][int'(bus.cnt_in)*DW +: DW] <= bus.data_in0;
            buf_data[wr_ptr][1][int'(bus.cnt_in)*DW +: DW] <= bus.data_in1;
            buf_data[wr_ptr][2][int'(bus.cnt_in)*DW +: DW] <= bus.data_in2;
            buf_data[wr_ptr][3][int'(bus.cnt_in)*DW +: DW] <= bus.data_in3;
            if (exp_cnt == '0) begin
                buf_pos[wr_ptr] <= bus.pos_in;
            end
        end
    end

`ifdef PWCOLLECT_DROP_CNT_EN
    // Saturating count of cycles where upstream offered a beat that stall turned away
    always_ff @(posedge clk) begin
        if (rst_b) begin
            drop_cnt <= '0;
        end else if (en && bus.in_valid && stall_q && (drop_cnt != 16'hFFFF)) begin
            drop_cnt <= drop_cnt + 16'd1;
        end
    end
`endif

    // The read buffer drives the output side directly so data stays put while valid
    always_comb begin
        bus.stall     = stall_q;
        bus.out_valid = buf_full[rd_ptr];
        bus.out_pos   = buf_pos[rd_ptr];
        bus.out_data0 = buf_data[rd_ptr][0];
        bus.out_data1 = buf_data[rd_ptr][1];
        bus.out_data2 = buf_data[rd_ptr][2];
        bus.out_data3 = buf_data[rd_ptr][3];
    end

endmodule
